// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//
// Single-port word-organised data SRAM with byte write enables and a
// registered response channel. Every cycle may carry one access and the
// block never stalls.
//
// Requests are checked before they are accepted. A request is rejected if it
// is misaligned or if it is outside the array. A rejected request leaves the
// memory untouched and produces a one-cycle error pulse in the next cycle.
//
// Ports
//   clk              : sole clock; all state updates on the rising edge
//   resetn           : synchronous reset, active HIGH (1 = reset)
//   data_sram_en     : access request this cycle
//   data_sram_wen    : byte write enables (bit i -> wdata[8i+7:8i]); 0 = read
//   data_sram_addr   : byte address; must be word aligned and inside the array
//   data_sram_wdata  : store data
//   data_sram_rdata  : registered response word (read data, or the merged
//                      word after a write; 0 after a rejected access)
//   data_sram_rvalid : rdata holds the result of a read accepted last cycle
//   data_sram_err    : one-cycle pulse for a request rejected last cycle
//   rd_cnt / wr_cnt  : accepted read / write counters (wrap at 2^32)
//
// The memory array is not cleared by reset. Its contents persist across reset.
// -----------------------------------------------------------------------------
module data_sram_resp #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        data_sram_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_READ,
    REQ_WRITE,
    REQ_REJECT
  } req_kind_e;

  logic [31:0]       mem_q [DEPTH];

  logic [31:0]       rdata_q,  rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q,    err_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;

  req_kind_e         req_kind;
  logic              aligned;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       cur_word;
  logic [31:0]       merged_word;
  logic              mem_we;

  // Request classification. Alignment is tested first. Misaligned and
  // out-of-range requests get the same response, so the order only matters
  // for readability.
  assign aligned  = (data_sram_addr[1:0] == 2'b00);
  assign in_range = ((data_sram_addr >> (ADDR_W + 2)) == 32'd0);
  assign word_idx = data_sram_addr[ADDR_W+1:2];

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so that no path through the block can infer a latch.
    req_kind = REQ_IDLE;
    if (data_sram_en) begin
      if (!aligned || !in_range) req_kind = REQ_REJECT;
      else if (data_sram_wen == 4'b0000) req_kind = REQ_READ;
      else req_kind = REQ_WRITE;
    end
  end

  // Write-first merge. The response word for a write is the word as it looks
  // after the enabled bytes are replaced.
  assign cur_word = mem_q[word_idx];

  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (data_sram_wen[b]) merged_word[8*b +: 8] = data_sram_wdata[8*b +: 8];
    end
  end

  // Next-state and response logic.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    unique case (req_kind)
      REQ_READ: begin
        rdata_d  = cur_word;
        rvalid_d = 1'b1;
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
      REQ_WRITE: begin
        rdata_d  = merged_word;
        wr_cnt_d = wr_cnt_q + 32'd1;
        // A request presented while reset is asserted must not reach the array.
        mem_we   = !resetn;
      end
      REQ_REJECT: begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from values taken before the clock edge.
  always_ff @(posedge clk) begin
    if (resetn) begin
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // NOTE: the memory array has no reset branch. Its contents survive reset, and
  // leaving it unreset keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_idx] <= merged_word;
  end

  assign data_sram_rdata  = rdata_q;
  assign data_sram_rvalid = rvalid_q;
  assign data_sram_err    = err_q;
  assign rd_cnt           = rd_cnt_q;
  assign wr_cnt           = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_resp
//
// Self-checking bench for data_sram_resp.
//
// The reference model holds the memory image as a plain word array. It
// applies the access rules using word arithmetic:
//   - aligned means addr % 4 == 0
//   - in range means addr < 4 * depth
// After each clock edge, the model predicts all five outputs.
//
// The bench runs in this order:
//   1. fill every word so that no later read returns an unknown value
//   2. directed scenarios
//   3. a randomized section
// -----------------------------------------------------------------------------
module tb_data_sram_resp;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic        data_sram_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  data_sram_resp #(.ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .data_sram_err    (data_sram_err),
    .rd_cnt           (rd_cnt),
    .wr_cnt           (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_err;
  logic [31:0] m_rd_cnt;
  logic [31:0] m_wr_cnt;

  int n_tests;
  int n_fail;

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Applies one clock edge worth of request to the reference model.
  task automatic model_step(logic rst, logic en, logic [3:0] wen,
                            logic [31:0] addr, logic [31:0] wd);
    int idx;
    if (rst) begin
      m_rdata  = 32'd0;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      m_rd_cnt = 32'd0;
      m_wr_cnt = 32'd0;
    end else if (!en) begin
      m_rvalid = 1'b0;
      m_err    = 1'b0;
    end else if ((addr % 4) != 0 || addr >= 32'(DEPTH * 4)) begin
      m_rdata  = 32'd0;
      m_rvalid = 1'b0;
      m_err    = 1'b1;
    end else begin
      idx   = int'(addr / 4);
      m_err = 1'b0;
      if (wen == 4'b0000) begin
        m_rdata  = m_mem[idx];
        m_rvalid = 1'b1;
        m_rd_cnt = m_rd_cnt + 32'd1;
      end else begin
        for (int b = 0; b < 4; b++)
          if (wen[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
        m_rdata  = m_mem[idx];
        m_rvalid = 1'b0;
        m_wr_cnt = m_wr_cnt + 32'd1;
      end
    end
  endtask

  // The caller sits 1 time unit after a rising edge. This task drives one
  // request, waits for the next rising edge, and then checks every output
  // against the model.
  task automatic cycle(string name, logic rst, logic en, logic [3:0] wen,
                       logic [31:0] addr, logic [31:0] wd);
    resetn          = rst;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    @(posedge clk);
    model_step(rst, en, wen, addr, wd);
    #1;
    check($sformatf("%s.rdata",  name), data_sram_rdata,         m_rdata);
    check($sformatf("%s.rvalid", name), 32'(data_sram_rvalid),   32'(m_rvalid));
    check($sformatf("%s.err",    name), 32'(data_sram_err),      32'(m_err));
    check($sformatf("%s.rd_cnt", name), rd_cnt,                  m_rd_cnt);
    check($sformatf("%s.wr_cnt", name), wr_cnt,                  m_wr_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] cnt_before;
    logic [31:0] a;
    logic [3:0]  w;
    logic        e;
    logic        r;
    int          sel;

    n_tests  = 0;
    n_fail   = 0;
    m_rdata  = 32'd0;
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    m_rd_cnt = 32'd0;
    m_wr_cnt = 32'd0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;

    // Reset state.
    cycle("reset0", 1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    cycle("reset1", 1'b1, 1'b0, 4'h0, 32'd0, 32'd0);

    // Fill the whole array with random words.
    for (int i = 0; i < DEPTH; i++)
      cycle("fill", 1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom);
    check("fill.wr_cnt_total", wr_cnt, 32'(DEPTH));

    // Reset clears the counters. The memory contents persist.
    cycle("reset2", 1'b1, 1'b0, 4'h0, 32'd0, 32'd0);

    // Full-word write to 0x10, then a read of 0x10.
    cycle("req26_wr", 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    cycle("req26_rd", 1'b0, 1'b1, 4'h0, 32'h10, 32'd0);
    check("req26.const_rdata", data_sram_rdata, 32'hDEADBEEF);
    check("req26.const_rdcnt", rd_cnt, 32'd1);
    check("req26.const_wrcnt", wr_cnt, 32'd1);

    // Partial write with wen = 0101.
    cycle("req27_wr", 1'b0, 1'b1, 4'b0101, 32'h10, 32'h11223344);
    check("req27.wr_rdata", data_sram_rdata, 32'hDE22BE44);
    cycle("req27_rd", 1'b0, 1'b1, 4'h0, 32'h10, 32'd0);
    check("req27.const_rdata", data_sram_rdata, 32'hDE22BE44);

    // An idle cycle holds rdata.
    cycle("idle_hold", 1'b0, 1'b0, 4'h0, 32'h10, 32'd0);

    // Rejected accesses: one misaligned, one out of range, and a write that
    // is both misaligned and out of range.
    cnt_before = rd_cnt;
    cycle("req28_mis", 1'b0, 1'b1, 4'h0, 32'h12, 32'd0);
    check("req28.const_err", 32'(data_sram_err), 32'd1);
    cycle("req28_oor", 1'b0, 1'b1, 4'h0, 32'h1000, 32'd0);
    check("req28.rdcnt_hold", rd_cnt, cnt_before);
    cycle("rej_wr_both", 1'b0, 1'b1, 4'hF, 32'h1002, 32'hFFFFFFFF);
    cycle("rej_wr_oor", 1'b0, 1'b1, 4'hF, 32'h8000_0010, 32'hFFFFFFFF);
    cycle("rej_followup_rd", 1'b0, 1'b1, 4'h0, 32'h10, 32'd0);

    // Back-to-back write/read pairs to 0x20 with no idle cycles.
    for (int i = 1; i <= 8; i++) begin
      cycle("req29_wr", 1'b0, 1'b1, 4'hF, 32'h20, 32'(i));
      cycle("req29_rd", 1'b0, 1'b1, 4'h0, 32'h20, 32'd0);
      check("req29.const_rdata", data_sram_rdata, 32'(i));
    end

    // A write presented during reset is ignored.
    cycle("req30_wr", 1'b0, 1'b1, 4'hF, 32'h0, 32'h00000055);
    cycle("req30_rst", 1'b1, 1'b1, 4'hF, 32'h0, 32'hFFFFFFFF);
    cycle("req30_rd", 1'b0, 1'b1, 4'h0, 32'h0, 32'd0);
    check("req30.const_rdata", data_sram_rdata, 32'h00000055);

    // Reset in the cycle after an accepted read discards the pending result.
    cycle("req25_rd", 1'b0, 1'b1, 4'h0, 32'h10, 32'd0);
    cycle("req25_rst", 1'b1, 1'b0, 4'h0, 32'h0, 32'd0);

    // The write counter wraps from 0xFFFFFFFF to 0.
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    m_wr_cnt = 32'hFFFF_FFFF;
    check("req31.preload", wr_cnt, 32'hFFFF_FFFF);
    cycle("req31_wr", 1'b0, 1'b1, 4'hF, 32'h40, 32'h0BADF00D);
    check("req31.const_wrap", wr_cnt, 32'd0);

    // Randomized traffic. Most requests target a small window of words so
    // that data is reused. A few requests target the whole array, and some
    // are misaligned or out of range.
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 19));
      r   = ($urandom_range(0, 49) == 0);
      e   = ($urandom_range(0, 7) != 0);
      w   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if (sel == 0)      a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | (32'd1 << (ADDR_W + 2 + int'($urandom_range(0, 19))));
      else if (sel == 2) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else               a = 32'($urandom_range(0, 7)) << 2;
      cycle("rand", r, e, w, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
